// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and ps2_host_tx.
// master: requester side (drives the byte and tx_valid).
// slave:  transmitter side (reports ready, busy, done and error).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err, tx_err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err, tx_err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte per request using
// open-drain pull-low enables on ps2_clk / ps2_data.
// Optional macro PS2_TX_RETRY_EN: on the first timeout or missing ACK the frame
// restarts once from INHIBIT with the latched byte; the second failure reports.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | lines released, tx_ready high, waiting for a request
// ST_INHIBIT   | ps2_clk pulled low (request-to-send); start bit on last cycle
// ST_SEND      | device clocks out data[7:0], parity, stop on its falling edges
// ST_ACK       | waiting for the device ACK falling edge (data must be low)
// ST_WAIT_IDLE | waiting for both lines to return high before reporting done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_drive_low,
  output logic         ps2_data_drive_low
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_SEND, ST_ACK, ST_WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  logic             clk_s1, clk_sync, clk_prev;
  logic             data_s1, data_sync;
  logic             fall;
  logic [9:0]       shreg;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] timer;
  logic             data_low_q;
  logic             done_q, err_q;
  logic [1:0]       err_code_q;
  logic [7:0]       load_byte;
  logic [9:0]       frame_word;

  logic       accept, start_frame, shift_bit, load_timeout, finish_ok, fail, retry;
  logic [1:0] fail_code;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] byte_q;
  logic       retried_q;
  assign load_byte = retry ? byte_q : bus.tx_data;
`else
  assign load_byte = bus.tx_data;
`endif

  // stop bit, odd parity, data; shifted out LSB first
  assign frame_word = {1'b1, ~^load_byte, load_byte};
  assign fall       = clk_prev & ~clk_sync;

  // Two-flop synchronizers on both pads plus previous clock value for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_s1   <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk_i;
      clk_sync  <= clk_s1;
      clk_prev  <= clk_sync;
      data_s1   <= ps2_data_i;
      data_sync <= data_s1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    start_frame  = 1'b0;
    shift_bit    = 1'b0;
    load_timeout = 1'b0;
    finish_ok    = 1'b0;
    fail         = 1'b0;
    fail_code    = ERR_TIMEOUT;
    retry        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          accept    = 1'b1;
          state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer == '0) begin
          start_frame  = 1'b1;
          load_timeout = 1'b1;
          state_nxt    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (fall) begin
          shift_bit    = 1'b1;
          load_timeout = 1'b1;
          if (bitcnt == 4'd9) state_nxt = ST_ACK;
        end else if (timer == '0) begin
          fail = 1'b1;
        end
      end
      ST_ACK: begin
        if (fall) begin
          load_timeout = 1'b1;
          if (!data_sync) begin
            state_nxt = ST_WAIT_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_NOACK;
          end
        end else if (timer == '0) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          finish_ok = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fall) begin
          load_timeout = 1'b1;
        end else if (timer == '0) begin
          fail = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef PS2_TX_RETRY_EN
    retry = fail & ~retried_q;
`endif
    if (fail) state_nxt = retry ? ST_INHIBIT : ST_IDLE;
  end

  // Shift register, bit counter, shared down-counter and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      timer      <= '0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      done_q <= finish_ok;
      err_q  <= fail & ~retry;
      if (fail && !retry) err_code_q <= fail_code;

      if (accept || retry) begin
        shreg  <= frame_word;
        bitcnt <= '0;
      end else if (shift_bit) begin
        shreg  <= {1'b0, shreg[9:1]};
        bitcnt <= bitcnt + 4'd1;
      end

      if (accept || retry)      timer <= INH_LOAD;
      else if (load_timeout)    timer <= TO_LOAD;
      else if (timer != '0)     timer <= timer - CNT_W'(1);

      if (accept || retry || fail || finish_ok) data_low_q <= 1'b0;
      else if (start_frame)                     data_low_q <= 1'b1;
      else if (shift_bit)                       data_low_q <= ~shreg[0];
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Latched byte for the single restart; the retry credit is renewed per request
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q    <= '0;
      retried_q <= 1'b0;
    end else if (accept) begin
      byte_q    <= bus.tx_data;
      retried_q <= 1'b0;
    end else if (retry) begin
      retried_q <= 1'b1;
    end
  end
`endif

  // Start bit is presented during the final inhibit cycle, before the clock is released
  assign ps2_clk_drive_low  = (state == ST_INHIBIT);
  assign ps2_data_drive_low = data_low_q | ((state == ST_INHIBIT) && (timer == '0));

  assign bus.tx_ready    = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.tx_err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_i, ps2_data_i, ps2_clk_drive_low, ps2_data_drive_low;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_err_cyc = 0;
  int last_fall_cyc = 0;
  logic [1:0] last_err_lines = 2'b00;

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .ps2_clk_i          (ps2_clk_i),
    .ps2_data_i         (ps2_data_i),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  // open-drain wired-AND with pull-ups
  assign ps2_clk_i  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled 2 ns after the active edge
  always begin
    @(posedge clk);
    #2;
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) begin
      err_cnt++;
      last_err_cyc   = cyc;
      last_err_lines = {ps2_clk_drive_low, ps2_data_drive_low};
    end
    if (bus.tx_done && bus.tx_err) both_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: what the device should see on its rising edges for byte b
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // counts negedge samples with clk pulled low; returns data drive during the last one
  task automatic wait_rts(output int low_cnt, output logic rts_data);
    int guard;
    guard = 0;
    low_cnt = 0;
    rts_data = 1'b0;
    while (!ps2_clk_drive_low && guard < 300) begin @(negedge clk); guard++; end
    while (ps2_clk_drive_low && low_cnt < 100) begin
      rts_data = ps2_data_drive_low;
      low_cnt++;
      @(negedge clk);
    end
  endtask

  // keyboard model: nfalls clock pulses sampling data before each rising edge, then ACK
  task automatic dev_frame(input int nfalls, input bit ack_phase, input bit ack,
                           output logic [9:0] bits);
    bits = '0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bits[i]     = ps2_data_i;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (ack_phase) begin
      repeat (HALF/2) @(negedge clk);
      dev_data_low  = ack;
      repeat (HALF/2) @(negedge clk);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF/2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] b);
    int lc, d0, e0;
    logic rd;
    logic [9:0] bits, exp;
    exp = ref_frame(b);
    d0 = done_cnt;
    e0 = err_cnt;
    request(b);
    n_cmp++;
    if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_%h: got ready=%b busy=%b expected ready=0 busy=1", b, bus.tx_ready, bus.busy);
    end
    wait_rts(lc, rd);
    n_cmp++;
    if (lc !== INH) begin n_bad++; $display("FAIL rts_len_%h: got %0d expected %0d", b, lc, INH); end
    n_cmp++;
    if (rd !== 1'b1) begin n_bad++; $display("FAIL start_bit_%h: got data_drive_low=%b expected 1", b, rd); end
    dev_frame(10, 1'b1, 1'b1, bits);
    n_cmp++;
    if (bits !== exp) begin n_bad++; $display("FAIL frame_%h: got %b expected %b", b, bits, exp); end
    wait_pulse(d0, e0, 200);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL done_%h: got done=%0d err=%0d expected done=1 err=0", b, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.tx_ready, bus.busy, bus.tx_done, bus.tx_err, bus.tx_err_code,
         ps2_clk_drive_low, ps2_data_drive_low} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%b busy=%b done=%b err=%b code=%b drv=%b%b expected 1 0 0 0 00 00",
               bus.tx_ready, bus.busy, bus.tx_done, bus.tx_err, bus.tx_err_code,
               ps2_clk_drive_low, ps2_data_drive_low);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    do_frame(8'hED);
  endtask

  task automatic test_parity;
    do_frame(8'hF4);
    do_frame(8'h00);
    do_frame(8'hFF);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) do_frame(8'($urandom_range(0, 255)));
  endtask

  task automatic test_timeout;
    int lc, d0, e0, dt;
    logic rd;
    logic [9:0] bits, exp;
    exp = ref_frame(8'h5A);
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'h5A);
    wait_rts(lc, rd);
    dev_frame(4, 1'b0, 1'b0, bits);
    n_cmp++;
    if (bits[3:0] !== exp[3:0]) begin n_bad++; $display("FAIL partial_bits: got %b expected %b", bits[3:0], exp[3:0]); end
`ifdef PS2_TX_RETRY_EN
    wait_rts(lc, rd);
    n_cmp++;
    if (lc !== INH || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL retry_rts: got len=%0d err=%0d expected len=%0d err=0", lc, err_cnt - e0, INH);
    end
    wait_pulse(d0, e0, 600);
`else
    wait_pulse(d0, e0, 400);
    // 200 cycles plus up to a few cycles of pad synchronizer latency
    dt = last_err_cyc - last_fall_cyc;
    n_cmp++;
    if (dt < TO || dt > TO + 5) begin n_bad++; $display("FAIL timeout_delay: got %0d expected %0d..%0d", dt, TO, TO + 5); end
`endif
    n_cmp++;
    if (err_cnt - e0 !== 1 || done_cnt !== d0 || bus.tx_err_code !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%0d done=%0d code=%b expected err=1 done=0 code=01",
               err_cnt - e0, done_cnt - d0, bus.tx_err_code);
    end
    n_cmp++;
    if (last_err_lines !== 2'b00) begin n_bad++; $display("FAIL timeout_lines: got %b expected 00", last_err_lines); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_noack;
    int lc, d0, e0;
    logic rd;
    logic [7:0] b;
    logic [9:0] bits;
    b  = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    e0 = err_cnt;
    request(b);
    wait_rts(lc, rd);
    dev_frame(10, 1'b1, 1'b0, bits);
`ifdef PS2_TX_RETRY_EN
    dev_frame(10, 1'b1, 1'b0, bits);
`endif
    wait_pulse(d0, e0, 200);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 !== 1 || done_cnt !== d0 || bus.tx_err_code !== 2'b10) begin
      n_bad++;
      $display("FAIL noack_err: got err=%0d done=%0d code=%b expected err=1 done=0 code=10",
               err_cnt - e0, done_cnt - d0, bus.tx_err_code);
    end
    n_cmp++;
    if (last_err_lines !== 2'b00 || {ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
      n_bad++;
      $display("FAIL noack_lines: got %b/%b expected 00", last_err_lines, {ps2_clk_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_mid_frame_reset;
    int lc, d0, e0;
    logic rd;
    logic [9:0] bits, exp;
    exp = ref_frame(8'hA7);
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'hA7);
    wait_rts(lc, rd);
    dev_frame(4, 1'b0, 1'b0, bits);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (ps2_data_drive_low !== ~exp[4]) begin
      n_bad++;
      $display("FAIL bit4_drive: got %b expected %b", ps2_data_drive_low, ~exp[4]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, bus.tx_ready, bus.tx_done, bus.tx_err} !== 5'b00100) begin
      n_bad++;
      $display("FAIL reset_mid: got drv=%b%b ready=%b done=%b err=%b expected drv=00 ready=1 done=0 err=0",
               ps2_clk_drive_low, ps2_data_drive_low, bus.tx_ready, bus.tx_done, bus.tx_err);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (TO + 100) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL reset_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    do_frame(8'hF4);
  endtask

  task automatic test_back_to_back;
    int lc, d0, e0;
    logic rd;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    bus.tx_data  = 8'hED;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_data  = 8'h12;
    wait_rts(lc, rd);
    dev_frame(10, 1'b1, 1'b1, bits);
    n_cmp++;
    if (bits !== ref_frame(8'hED)) begin n_bad++; $display("FAIL b2b_first: got %b expected %b", bits, ref_frame(8'hED)); end
    wait_pulse(d0, e0, 200);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL b2b_done1: got %0d expected 1", done_cnt - d0); end
    wait_rts(lc, rd);
    bus.tx_valid = 1'b0;
    n_cmp++;
    if (lc !== INH) begin n_bad++; $display("FAIL b2b_rts: got %0d expected %0d", lc, INH); end
    dev_frame(10, 1'b1, 1'b1, bits);
    n_cmp++;
    if (bits !== ref_frame(8'h12)) begin n_bad++; $display("FAIL b2b_second: got %b expected %b", bits, ref_frame(8'h12)); end
    wait_pulse(d0 + 1, e0, 200);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 2 || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL b2b_done2: got done=%0d err=%0d expected done=2 err=0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_no_overlap;
    n_cmp++;
    if (both_cnt !== 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset;
    test_basic;
    test_parity;
    test_random;
    test_timeout;
    test_noack;
    test_mid_frame_reset;
    test_back_to_back;
    test_no_overlap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
